// File: rtl/control_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | control_pkg                                                           |
// | Shared FSM state, opcode and datapath-select encodings for the core.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package control_pkg;

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    FETCH_WAIT = 4'd1,
    DECODE     = 4'd2,
    EXEC_R     = 4'd3,
    EXEC_I     = 4'd4,
    ADDR       = 4'd5,
    LOAD       = 4'd6,
    LOAD_WB    = 4'd7,
    STORE      = 4'd8,
    BRANCH     = 4'd9,
    JAL        = 4'd10,
    JALR       = 4'd11,
    LUI        = 4'd12,
    ALU_WB     = 4'd13,
    HALT       = 4'd14,
    ERROR      = 4'd15
  } state_t;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  localparam logic [2:0] c_f3_beq = 3'b000;
  localparam logic [2:0] c_f3_bne = 3'b001;

  localparam logic [2:0] c_imm_i  = 3'd0;
  localparam logic [2:0] c_imm_s  = 3'd1;
  localparam logic [2:0] c_imm_sb = 3'd2;
  localparam logic [2:0] c_imm_u  = 3'd3;
  localparam logic [2:0] c_imm_uj = 3'd4;

  localparam logic [2:0] c_alu_add = 3'd0;
  localparam logic [2:0] c_alu_sub = 3'd1;
  localparam logic [2:0] c_alu_r   = 3'd2;
  localparam logic [2:0] c_alu_i   = 3'd3;

  localparam logic [1:0] c_a_pc   = 2'd0;
  localparam logic [1:0] c_a_rs1  = 2'd1;
  localparam logic [1:0] c_a_zero = 2'd2;

  localparam logic [1:0] c_b_rs2  = 2'd0;
  localparam logic [1:0] c_b_four = 2'd1;
  localparam logic [1:0] c_b_imm  = 2'd2;

  localparam logic [1:0] c_pc_alu    = 2'd0;
  localparam logic [1:0] c_pc_target = 2'd1;
  localparam logic [1:0] c_pc_jalr   = 2'd2;

  // Opcode dispatch out of DECODE; anything unrecognised traps.
  function automatic state_t dispatch(input logic [6:0] opcode);
    case (opcode)
      c_op_r:               dispatch = EXEC_R;
      c_op_i:               dispatch = EXEC_I;
      c_op_load, c_op_store: dispatch = ADDR;
      c_op_branch:          dispatch = BRANCH;
      c_op_jal:             dispatch = JAL;
      c_op_jalr:            dispatch = JALR;
      c_op_lui:             dispatch = LUI;
      c_op_system:          dispatch = HALT;
      default:              dispatch = ERROR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_wait_timer                                                        |
// | Counts stalled memory-wait cycles and flags a bus timeout.            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int c_cnt_w = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MEM_TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               w_stall;

  assign w_stall = active && !mem_ready;
  // Ready in the final permitted cycle still completes the access.
  assign timeout = w_stall && (r_count == c_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_stall && !timeout) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | control_unit                                                          |
// | Multi-cycle RV32 subset control FSM with memory-wait timeout.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module control_unit
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  imm_type,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        halt,
  output logic        error
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_wait_active;
  logic       w_timeout;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused_instr;

  assign w_opcode       = instr[6:0];
  assign w_funct3       = instr[14:12];
  assign w_unused_instr = ^{instr[31:15], instr[11:7]};
  assign w_wait_active  = (r_state == FETCH_WAIT) || (r_state == LOAD) ||
                          (r_state == STORE);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (w_wait_active),
    .mem_ready (mem_ready),
    .timeout   (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = c_pc_alu;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    imm_type     = c_imm_i;
    alu_src_a    = c_a_pc;
    alu_src_b    = c_b_rs2;
    alu_op       = c_alu_add;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    halt         = 1'b0;
    error        = 1'b0;

    case (r_state)
      FETCH: begin
        mem_read     = 1'b1;
        w_next_state = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        mem_read  = 1'b1;
        alu_src_a = c_a_pc;
        alu_src_b = c_b_four;
        alu_op    = c_alu_add;
        pc_src    = c_pc_alu;
        // IR and PC+4 are captured in the cycle the fetch data is valid.
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = DECODE;
        end else if (w_timeout) begin
          w_next_state = ERROR;
        end
      end
      DECODE: begin
        imm_type     = c_imm_sb;
        alu_src_a    = c_a_pc;
        alu_src_b    = c_b_imm;
        alu_op       = c_alu_add;
        w_next_state = dispatch(w_opcode);
      end
      EXEC_R: begin
        alu_src_a    = c_a_rs1;
        alu_src_b    = c_b_rs2;
        alu_op       = c_alu_r;
        w_next_state = ALU_WB;
      end
      EXEC_I: begin
        imm_type     = c_imm_i;
        alu_src_a    = c_a_rs1;
        alu_src_b    = c_b_imm;
        alu_op       = c_alu_i;
        w_next_state = ALU_WB;
      end
      ADDR: begin
        alu_src_a = c_a_rs1;
        alu_src_b = c_b_imm;
        alu_op    = c_alu_add;
        if (w_opcode == c_op_store) begin
          imm_type     = c_imm_s;
          w_next_state = STORE;
        end else begin
          imm_type     = c_imm_i;
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          w_next_state = LOAD_WB;
        end else if (w_timeout) begin
          w_next_state = ERROR;
        end
      end
      LOAD_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        w_next_state = FETCH;
      end
      STORE: begin
        mem_write = 1'b1;
        if (mem_ready) begin
          w_next_state = FETCH;
        end else if (w_timeout) begin
          w_next_state = ERROR;
        end
      end
      BRANCH: begin
        alu_src_a    = c_a_rs1;
        alu_src_b    = c_b_rs2;
        alu_op       = c_alu_sub;
        w_next_state = FETCH;
        case (w_funct3)
          c_f3_beq: begin
            pc_write = zero;
            pc_src   = zero ? c_pc_target : c_pc_alu;
          end
          c_f3_bne: begin
            pc_write = !zero;
            pc_src   = zero ? c_pc_alu : c_pc_target;
          end
          default: w_next_state = ERROR;
        endcase
      end
      JAL: begin
        imm_type     = c_imm_uj;
        alu_src_a    = c_a_pc;
        alu_src_b    = c_b_imm;
        alu_op       = c_alu_add;
        pc_src       = c_pc_alu;
        pc_write     = 1'b1;
        reg_write    = 1'b1;
        w_next_state = FETCH;
      end
      JALR: begin
        imm_type     = c_imm_i;
        alu_src_a    = c_a_rs1;
        alu_src_b    = c_b_imm;
        alu_op       = c_alu_add;
        pc_src       = c_pc_jalr;
        pc_write     = 1'b1;
        reg_write    = 1'b1;
        w_next_state = FETCH;
      end
      LUI: begin
        imm_type     = c_imm_u;
        alu_src_a    = c_a_zero;
        alu_src_b    = c_b_imm;
        alu_op       = c_alu_add;
        w_next_state = ALU_WB;
      end
      ALU_WB: begin
        reg_write    = 1'b1;
        w_next_state = FETCH;
      end
      HALT: begin
        halt = 1'b1;
      end
      ERROR: begin
        halt  = 1'b1;
        error = 1'b1;
      end
      default: w_next_state = ERROR;
    endcase

    // Strobes must drop the instant reset rises, not at the next edge.
    if (reset) begin
      w_next_state = FETCH;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = c_pc_alu;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      imm_type     = c_imm_i;
      alu_src_a    = c_a_pc;
      alu_src_b    = c_b_rs2;
      alu_op       = c_alu_add;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      halt         = 1'b0;
      error        = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_control_unit                                                       |
// | Directed per-cycle vector bench for control_unit.                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_control_unit;
  import control_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, mem_read, mem_write;
  logic        reg_write, mem_to_reg, halt, error;
  logic [1:0]  pc_src, alu_src_a, alu_src_b;
  logic [2:0]  imm_type, alu_op;
  logic [19:0] w_out;

  int n_cmp;
  int n_bad;

  control_unit #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .imm_type   (imm_type),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .halt       (halt),
    .error      (error)
  );

  assign w_out = {ir_write, pc_write, pc_src, mem_read, mem_write, imm_type,
                  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, halt, error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        z;
    logic        rdy;
    state_t      st;
    logic [19:0] out;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_BEQ    = 32'h0020_8463;
  localparam logic [31:0] I_BNE    = 32'h0020_9463;
  localparam logic [31:0] I_BLT    = 32'h0020_C463;
  localparam logic [31:0] I_LW     = 32'h0000_A183;
  localparam logic [31:0] I_SW     = 32'h0030_A023;
  localparam logic [31:0] I_LUI    = 32'h1234_50B7;
  localparam logic [31:0] I_JAL    = 32'h0080_00EF;
  localparam logic [31:0] I_JALR   = 32'h0000_80E7;
  localparam logic [31:0] I_ADD    = 32'h0020_81B3;
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_ILL    = 32'h0000_007F;

  // Field order: ir_write pc_write pc_src mem_read mem_write imm_type
  //              alu_src_a alu_src_b alu_op reg_write mem_to_reg halt error
  function automatic logic [19:0] o(input int ir, pcw, pcs, mr, mw, imm, a, b,
                                    op, rw, m2r, h, e);
    return {1'(ir), 1'(pcw), 2'(pcs), 1'(mr), 1'(mw), 3'(imm), 2'(a), 2'(b),
            3'(op), 1'(rw), 1'(m2r), 1'(h), 1'(e)};
  endfunction

  logic [19:0] e_rst, e_f, e_fwr, e_fww, e_dec, e_exi, e_exr, e_wb, e_bt, e_bn;
  logic [19:0] e_al, e_as, e_ld, e_lwb, e_st, e_lui, e_jal, e_jalr, e_halt, e_err;

  task automatic v(input logic r, input logic [31:0] in, input logic z,
                   input logic rdy, input state_t s, input logic [19:0] out,
                   input string nm);
    vec_t t;
    t.rst = r; t.ins = in; t.z = z; t.rdy = rdy; t.st = s; t.out = out; t.nm = nm;
    tbl.push_back(t);
  endtask

  task automatic fetch3(input logic [31:0] in, input logic z, input string nm);
    v(0, in, z, 0, FETCH,      e_f,   {nm, "_fetch"});
    v(0, in, z, 1, FETCH_WAIT, e_fwr, {nm, "_fwait"});
    v(0, in, z, 0, DECODE,     e_dec, {nm, "_decode"});
  endtask

  task automatic check(input state_t es, input logic [19:0] eo, input string nm);
    n_cmp++;
    if (dut.r_state !== es) begin
      n_bad++;
      $display("FAIL %s state: got %0d expected %0d", nm, dut.r_state, es);
    end
    n_cmp++;
    if (w_out !== eo) begin
      n_bad++;
      $display("FAIL %s outputs: got %05h expected %05h", nm, w_out, eo);
    end
  endtask

  // Called just after a rising edge; compares mid-cycle, returns after next edge.
  task automatic step(input logic r, input logic [31:0] in, input logic z,
                      input logic rdy, input state_t es, input logic [19:0] eo,
                      input string nm);
    reset = r; instr = in; zero = z; mem_ready = rdy;
    @(negedge clk);
    check(es, eo, nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; instr = '0; zero = 1'b0; mem_ready = 1'b0;

    e_rst  = o(0,0,0,0,0,0,0,0,0,0,0,0,0);
    e_f    = o(0,0,0,1,0,0,0,0,0,0,0,0,0);
    e_fwr  = o(1,1,0,1,0,0,0,1,0,0,0,0,0);
    e_fww  = o(0,0,0,1,0,0,0,1,0,0,0,0,0);
    e_dec  = o(0,0,0,0,0,2,0,2,0,0,0,0,0);
    e_exi  = o(0,0,0,0,0,0,1,2,3,0,0,0,0);
    e_exr  = o(0,0,0,0,0,0,1,0,2,0,0,0,0);
    e_wb   = o(0,0,0,0,0,0,0,0,0,1,0,0,0);
    e_bt   = o(0,1,1,0,0,0,1,0,1,0,0,0,0);
    e_bn   = o(0,0,0,0,0,0,1,0,1,0,0,0,0);
    e_al   = o(0,0,0,0,0,0,1,2,0,0,0,0,0);
    e_as   = o(0,0,0,0,0,1,1,2,0,0,0,0,0);
    e_ld   = o(0,0,0,1,0,0,0,0,0,0,0,0,0);
    e_lwb  = o(0,0,0,0,0,0,0,0,0,1,1,0,0);
    e_st   = o(0,0,0,0,1,0,0,0,0,0,0,0,0);
    e_lui  = o(0,0,0,0,0,3,2,2,0,0,0,0,0);
    e_jal  = o(0,1,0,0,0,4,0,2,0,1,0,0,0);
    e_jalr = o(0,1,2,0,0,0,1,2,0,1,0,0,0);
    e_halt = o(0,0,0,0,0,0,0,0,0,0,0,1,0);
    e_err  = o(0,0,0,0,0,0,0,0,0,0,0,1,1);

    v(1, '0, 0, 0, FETCH, e_rst, "reset");
    fetch3(I_ADDI, 0, "addi");
    v(0, I_ADDI, 0, 0, EXEC_I, e_exi, "addi_exec");
    v(0, I_ADDI, 0, 0, ALU_WB, e_wb,  "addi_wb");
    fetch3(I_BEQ, 1, "beq_t");
    v(0, I_BEQ, 1, 0, BRANCH, e_bt, "beq_taken");
    fetch3(I_BEQ, 0, "beq_n");
    v(0, I_BEQ, 0, 0, BRANCH, e_bn, "beq_not_taken");
    fetch3(I_BNE, 0, "bne_t");
    v(0, I_BNE, 0, 0, BRANCH, e_bt, "bne_taken");
    fetch3(I_LW, 0, "lw");
    v(0, I_LW, 0, 0, ADDR,    e_al,  "lw_addr");
    v(0, I_LW, 0, 0, LOAD,    e_ld,  "lw_wait1");
    v(0, I_LW, 0, 0, LOAD,    e_ld,  "lw_wait2");
    v(0, I_LW, 0, 0, LOAD,    e_ld,  "lw_wait3");
    v(0, I_LW, 0, 1, LOAD,    e_ld,  "lw_ready");
    v(0, I_LW, 0, 0, LOAD_WB, e_lwb, "lw_wb");
    fetch3(I_SW, 0, "sw");
    v(0, I_SW, 0, 0, ADDR,  e_as, "sw_addr");
    v(0, I_SW, 0, 1, STORE, e_st, "sw_store");
    fetch3(I_LUI, 0, "lui");
    v(0, I_LUI, 0, 0, LUI,    e_lui, "lui_exec");
    v(0, I_LUI, 0, 0, ALU_WB, e_wb,  "lui_wb");
    fetch3(I_JAL, 0, "jal");
    v(0, I_JAL, 0, 0, JAL, e_jal, "jal_exec");
    fetch3(I_JALR, 0, "jalr");
    v(0, I_JALR, 0, 0, JALR, e_jalr, "jalr_exec");
    fetch3(I_ADD, 0, "add");
    v(0, I_ADD, 0, 0, EXEC_R, e_exr, "add_exec");
    v(0, I_ADD, 0, 0, ALU_WB, e_wb,  "add_wb");
    fetch3(I_EBREAK, 0, "ebreak");
    v(0, I_EBREAK, 0, 0, HALT, e_halt, "ebreak_halt");
    v(0, I_EBREAK, 0, 1, HALT, e_halt, "ebreak_stays");
    v(1, '0, 0, 0, FETCH, e_rst, "reset_after_halt");
    fetch3(I_ILL, 0, "illegal");
    v(0, I_ILL, 0, 0, ERROR, e_err, "illegal_error");
    v(0, I_ILL, 0, 1, ERROR, e_err, "illegal_stays");
    v(1, '0, 0, 0, FETCH, e_rst, "reset_after_error");
    fetch3(I_BLT, 0, "blt");
    v(0, I_BLT, 0, 0, BRANCH, e_bn,  "blt_branch");
    v(0, I_BLT, 0, 0, ERROR,  e_err, "blt_error");
    v(1, '0, 0, 0, FETCH, e_rst, "reset_after_blt");

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].ins, tbl[i].z, tbl[i].rdy, tbl[i].st, tbl[i].out, tbl[i].nm);
    end

    // Fetch never acknowledged: fifteen wait cycles then a bus error.
    step(0, I_ADDI, 0, 0, FETCH, e_f, "to_fetch");
    for (int k = 0; k < 15; k++) begin
      step(0, I_ADDI, 0, 0, FETCH_WAIT, e_fww, "to_wait");
    end
    step(0, I_ADDI, 0, 0, ERROR, e_err, "to_error");
    step(1, I_ADDI, 0, 0, FETCH, e_rst, "to_reset");

    // Ready arriving in the last permitted wait cycle completes the fetch.
    step(0, I_ADDI, 0, 0, FETCH, e_f, "rw_fetch");
    for (int k = 0; k < 14; k++) begin
      step(0, I_ADDI, 0, 0, FETCH_WAIT, e_fww, "rw_wait");
    end
    step(0, I_ADDI, 0, 1, FETCH_WAIT, e_fwr, "rw_ready");
    step(0, I_ADDI, 0, 0, DECODE, e_dec, "rw_decode");
    step(0, I_ADDI, 0, 0, EXEC_I, e_exi, "rw_exec");
    step(0, I_ADDI, 0, 0, ALU_WB, e_wb,  "rw_wb");

    // Reset mid-store must drop mem_write without waiting for a clock edge.
    step(0, I_SW, 0, 0, FETCH,      e_f,   "rs_fetch");
    step(0, I_SW, 0, 1, FETCH_WAIT, e_fwr, "rs_fwait");
    step(0, I_SW, 0, 0, DECODE,     e_dec, "rs_decode");
    step(0, I_SW, 0, 0, ADDR,       e_as,  "rs_addr");
    step(0, I_SW, 0, 0, STORE,      e_st,  "rs_store1");
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check(STORE, e_st, "rs_store2");
    reset = 1'b1;
    #1;
    check(FETCH, e_rst, "rs_async_drop");
    @(posedge clk);
    #1;
    step(0, I_SW, 0, 0, FETCH, e_f, "rs_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum cycles to wait for mem_ready before declaring a bus error.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears FSM and counter immediately.
REQ-004 instr  input  32  current instruction register contents.
REQ-005 zero  input  1  ALU zero flag for the current compare.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 ir_write  output  1  load instruction register from memory data.
REQ-008 pc_write  output  1  unconditional PC update.
REQ-009 pc_src  output  2  PC source: 0 = ALU result, 1 = branch/jump target register, 2 = ALU result with bit 0 cleared (jalr).
REQ-010 mem_read / mem_write  output  1 each  memory access strobes, held until mem_ready.
REQ-011 imm_type  output  3  immediate format select to sign extender: I=0, S=1, SB=2, U=3, UJ=4.
REQ-012 alu_src_a  output  2  0 = PC, 1 = rs1, 2 = zero.
REQ-013 alu_src_b  output  2  0 = rs2, 1 = constant 4, 2 = immediate.
REQ-014 alu_op  output  3  0 = add, 1 = sub, 2 = decode funct3/funct7 (R), 3 = decode funct3 (I).
REQ-015 reg_write  output  1  write rd; mem_to_reg  output  1  rd data from memory (1) or ALU/target (0).
REQ-016 halt  output  1  core stopped; error  output  1  illegal opcode or memory timeout.

Function
REQ-017 FSM states SHALL be: FETCH, FETCH_WAIT, DECODE, EXEC_R, EXEC_I, ADDR, LOAD, LOAD_WB, STORE, BRANCH, JAL, JALR, LUI, ALU_WB, HALT, ERROR.
REQ-018 FETCH: mem_read=1, next FETCH_WAIT; FETCH_WAIT: mem_read=1, on mem_ready assert ir_write=1, pc_write=1 (PC+4, alu_src_a=0, alu_src_b=1, pc_src=0), go DECODE.
REQ-019 DECODE SHALL compute branch target PC+imm (imm_type=SB) into target register and dispatch on instr[6:0]: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->ADDR, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 1110011->HALT, other->ERROR.
REQ-020 Dispatch SHALL use an explicit default; no opcode SHALL leave imm_type or next state unassigned.
REQ-021 EXEC_R (alu_op=2) and EXEC_I (alu_op=3, imm_type=I) SHALL go to ALU_WB; ALU_WB asserts reg_write=1, mem_to_reg=0, then FETCH.
REQ-022 ADDR: alu_src_a=1, alu_src_b=2, alu_op=0, imm_type=I for load, S for store; next LOAD or STORE.
REQ-023 LOAD holds mem_read=1 until mem_ready, then LOAD_WB (reg_write=1, mem_to_reg=1) then FETCH; STORE holds mem_write=1 until mem_ready, then FETCH.
REQ-024 BRANCH: alu_op=1, rs1 vs rs2; funct3 000 (beq) takes if zero=1, 001 (bne) if zero=0; taken -> pc_write=1, pc_src=1; other funct3 -> ERROR; next FETCH.
REQ-025 JAL (imm_type=UJ) and JALR (imm_type=I, pc_src=2) SHALL write rd with old PC+4 and update PC in one cycle, then FETCH.
REQ-026 LUI: imm_type=U, alu_src_a=2, alu_src_b=2, alu_op=0, then ALU_WB.
REQ-027 Wait counter SHALL count cycles in FETCH_WAIT, LOAD, STORE with mem_ready=0, clear on state exit; reaching MEM_TIMEOUT SHALL go ERROR.
REQ-028 mem_ready asserted in the same cycle the count reaches MEM_TIMEOUT SHALL complete the access (ready wins).
REQ-029 HALT and ERROR are terminal until reset; halt=1 in both, error=1 only in ERROR; all strobes 0.
REQ-030 All outputs SHALL be combinational from state and instr only; no strobe SHALL assert in two consecutive instructions without passing FETCH.

Reset
REQ-031 On reset: state=FETCH, counter=0; all write/read strobes, halt, error = 0; selects = 0.
REQ-032 Reset mid-access SHALL drop mem_read/mem_write in the same cycle (asynchronous).

Structure
REQ-033 Package control_pkg SHALL hold the state enum, opcode constants, imm_type, alu_op, alu_src and pc_src encodings shared with the sign extender and ALU control.
REQ-034 One sub-module, mem_wait_timer (counter and timeout flag), is natural; the rest is one FSM.

Verification
REQ-035 addi x1,x0,5 (0x00500093), mem_ready immediate -> FETCH,FETCH_WAIT,DECODE,EXEC_I,ALU_WB; reg_write one cycle, imm_type=0.
REQ-036 beq with zero=1 -> pc_write and pc_src=1 in BRANCH; zero=0 -> no pc_write.
REQ-037 lw with mem_ready delayed 3 cycles -> mem_read held 4 cycles, LOAD_WB with mem_to_reg=1.
REQ-038 mem_ready never asserted in FETCH_WAIT -> ERROR after 15 cycles, error=1, halt=1.
REQ-039 Opcode 0x7F -> ERROR from DECODE; ebreak 0x00100073 -> HALT, error=0.
REQ-040 reset asserted during STORE wait -> mem_write low immediately, FETCH after release.
